// File: rtl/rgmii_rx_delay_cal.sv
// RGMII receive IDELAY calibration: sweeps taps, checks preamble/SFD
// framing at each point, and centers the delay in the widest good window.
module rgmii_rx_delay_cal #(
  parameter int TAP_STEP       = 32,
  parameter int TAP_MAX        = 511,
  parameter int FRAMES_PER_TAP = 4,
  parameter int TIMEOUT        = 65536,
  parameter int MIN_WIN        = 3
) (
  input  logic       gmii_rx_clk,
  input  logic       RES_N,
  input  logic       cal_start,
  input  logic       idelay_rdy,
  input  logic       gmii_rx_dv,
  input  logic [7:0] gmii_rxd,
  output logic       dly_load,
  output logic [8:0] dly_cntvalue,
  output logic       cal_busy,
  output logic       cal_done,
  output logic       cal_fail,
  output logic [8:0] cal_tap
);

  typedef enum logic [3:0] {
    IDLE, WAIT_RDY, LOAD, SETTLE, MEASURE,
    EVAL, CENTER, DONE, FAIL
  } state_t;

  state_t      state, state_n;
  logic        rdy_m, rdy_s;
  logic        dv_q, fr_act, pass_q;
  logic [3:0]  settle_cnt, pre_cnt, pcnt;
  logic [15:0] good_cnt;
  logic [31:0] to_cnt;
  logic [8:0]  sweep_tap, run_start, best_start;
  logic [8:0]  ext_start, cnt_q, center;
  logic [9:0]  run_len, best_len, ext_len;
  logic [10:0] nxt_tap;
  logic        parsing, fr_good, fr_bad, fr_cont;
  logic        timeout, pt_pass, pt_done;
  logic        last_pt, win_ok, start_ok, rdy_lost;

  assign start_ok = cal_start &&
    (state == IDLE || state == DONE || state == FAIL);
  assign rdy_lost = !rdy_s &&
    (state == LOAD || state == SETTLE ||
     state == MEASURE || state == EVAL);

  // A frame is only parsed from a dv rising edge seen in MEASURE
  assign parsing = fr_act | (gmii_rx_dv & ~dv_q);
  assign pcnt    = fr_act ? pre_cnt : 4'd0;

  always_comb begin
    fr_good = 1'b0;
    fr_bad  = 1'b0;
    fr_cont = 1'b0;
    if (state == MEASURE && parsing) begin
      unique case (1'b1)
        !gmii_rx_dv:
          fr_bad = 1'b1;
        gmii_rx_dv && gmii_rxd == 8'h55: begin
          if (pcnt == 4'd7) fr_bad = 1'b1;
          else fr_cont = 1'b1;
        end
        gmii_rx_dv && gmii_rxd == 8'hD5: begin
          if (pcnt == 4'd0) fr_bad = 1'b1;
          else fr_good = 1'b1;
        end
        default:
          fr_bad = 1'b1;
      endcase
    end
  end

  assign timeout = to_cnt == 32'(TIMEOUT - 1);
  assign pt_pass = fr_good &&
    good_cnt == 16'(FRAMES_PER_TAP - 1);
  assign pt_done = pt_pass | fr_bad | timeout;

  assign ext_len   = pass_q ? run_len + 10'd1 : run_len;
  assign ext_start = (pass_q && run_len == 10'd0) ?
    sweep_tap : run_start;
  assign nxt_tap   = {2'b00, sweep_tap} + 11'(TAP_STEP);
  assign last_pt   = nxt_tap > 11'(TAP_MAX);
  assign win_ok    = best_len >= 10'(MIN_WIN);
  assign center    = best_start + 9'(
    ((32'(best_len) - 32'd1) * 32'(TAP_STEP)) >> 1);

  always_comb begin
    state_n = state;
    if (start_ok || rdy_lost) begin
      state_n = WAIT_RDY;
    end else begin
      case (state)
        WAIT_RDY: if (rdy_s) state_n = LOAD;
        LOAD:     state_n = SETTLE;
        SETTLE:   if (settle_cnt == 4'd15) state_n = MEASURE;
        MEASURE:  if (pt_done) state_n = EVAL;
        EVAL:     state_n = last_pt ? CENTER : LOAD;
        CENTER:   state_n = win_ok ? DONE : FAIL;
        default:  state_n = state;
      endcase
    end
  end

  always_comb begin
    dly_load     = (state == LOAD) || (state == CENTER);
    dly_cntvalue = cnt_q;
    if (state == LOAD) dly_cntvalue = sweep_tap;
    else if (state == CENTER) dly_cntvalue = win_ok ? center : 9'd0;
  end

  assign cal_busy = !(state == IDLE || state == DONE ||
                      state == FAIL);
  assign cal_done = state == DONE;
  assign cal_fail = state == FAIL;

  always_ff @(posedge gmii_rx_clk or negedge RES_N) begin
    if (!RES_N) state <= IDLE;
    else state <= state_n;
  end

  always_ff @(posedge gmii_rx_clk or negedge RES_N) begin
    if (!RES_N) begin
      rdy_m      <= 1'b0;
      rdy_s      <= 1'b0;
      dv_q       <= 1'b0;
      fr_act     <= 1'b0;
      pass_q     <= 1'b0;
      settle_cnt <= '0;
      pre_cnt    <= '0;
      good_cnt   <= '0;
      to_cnt     <= '0;
      sweep_tap  <= '0;
      run_start  <= '0;
      run_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
      cnt_q      <= '0;
      cal_tap    <= '0;
    end else begin
      rdy_m <= idelay_rdy;
      rdy_s <= rdy_m;
      dv_q  <= gmii_rx_dv;
      cnt_q <= dly_cntvalue;
      if (start_ok || rdy_lost) begin
        sweep_tap  <= '0;
        run_start  <= '0;
        run_len    <= '0;
        best_start <= '0;
        best_len   <= '0;
        fr_act     <= 1'b0;
      end else begin
        case (state)
          LOAD: settle_cnt <= '0;
          SETTLE: begin
            settle_cnt <= settle_cnt + 4'd1;
            good_cnt   <= '0;
            to_cnt     <= '0;
            fr_act     <= 1'b0;
          end
          MEASURE: begin
            to_cnt <= to_cnt + 32'd1;
            fr_act <= fr_cont;
            if (fr_cont) pre_cnt <= pcnt + 4'd1;
            if (fr_good) good_cnt <= good_cnt + 16'd1;
            if (pt_done) pass_q <= pt_pass;
          end
          EVAL: begin
            // Close the run on a failing point or at sweep end
            if (!pass_q || last_pt) begin
              if (ext_len > best_len) begin
                best_len   <= ext_len;
                best_start <= ext_start;
              end
              run_len <= '0;
            end else begin
              run_len   <= ext_len;
              run_start <= ext_start;
            end
            if (!last_pt) sweep_tap <= nxt_tap[8:0];
          end
          CENTER: cal_tap <= win_ok ? center : 9'd0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rgmii_rx_delay_cal.sv
// Directed bench for rgmii_rx_delay_cal with a tap-dependent frame source.
module tb_rgmii_rx_delay_cal;

  logic       clk = 1'b0;
  logic       RES_N;
  logic       cal_start;
  logic       idelay_rdy;
  logic       gmii_rx_dv;
  logic [7:0] gmii_rxd;
  logic       dly_load;
  logic [8:0] dly_cntvalue;
  logic       cal_busy, cal_done, cal_fail;
  logic [8:0] cal_tap;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lq[$];
  int lt[$];
  int gen_mode = 0;
  int data_len = 4;
  int lo1 = -1, hi1 = -1, lo2 = -1, hi2 = -1;
  int gtap;
  bit ggood;
  int v;

  rgmii_rx_delay_cal #(.TIMEOUT(400)) dut (
    .gmii_rx_clk (clk),
    .RES_N       (RES_N),
    .cal_start   (cal_start),
    .idelay_rdy  (idelay_rdy),
    .gmii_rx_dv  (gmii_rx_dv),
    .gmii_rxd    (gmii_rxd),
    .dly_load    (dly_load),
    .dly_cntvalue(dly_cntvalue),
    .cal_busy    (cal_busy),
    .cal_done    (cal_done),
    .cal_fail    (cal_fail),
    .cal_tap     (cal_tap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dly_load === 1'b1) begin
      lq.push_back(int'(dly_cntvalue));
      lt.push_back(cyc);
    end
  end

  // Channel model: frame quality follows the tap applied at frame start
  initial begin
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    forever begin
      if (gen_mode == 0) begin
        @(negedge clk);
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
      end else begin
        repeat (4) begin
          @(negedge clk);
          gmii_rx_dv = 1'b0;
          gmii_rxd   = 8'h00;
        end
        gtap  = int'(dly_cntvalue);
        ggood = gen_mode == 1 &&
          ((gtap >= lo1 && gtap <= hi1) ||
           (gtap >= lo2 && gtap <= hi2));
        for (int i = 0; i < 7; i++) begin
          @(negedge clk);
          gmii_rx_dv = 1'b1;
          gmii_rxd   = 8'h55;
        end
        @(negedge clk);
        gmii_rxd = ggood ? 8'hD5 : 8'hD4;
        for (int i = 0; i < data_len; i++) begin
          @(negedge clk);
          gmii_rxd = 8'(i + 1);
        end
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(cal_done === 1'b1 || cal_fail === 1'b1) &&
           n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("end_reached", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_load_v(input int val, input int budget);
    int n = 0;
    @(negedge clk);
    while (!(dly_load === 1'b1 && int'(dly_cntvalue) == val) &&
           n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("load_seen", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_load(input int budget, output int val);
    int n = 0;
    @(negedge clk);
    while (dly_load !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("next_load_seen", 32'(n < budget), 32'd1);
    val = (n < budget) ? int'(dly_cntvalue) : -1;
  endtask

  task automatic clear_log();
    lq.delete();
    lt.delete();
  endtask

  initial begin
    RES_N      = 1'b0;
    cal_start  = 1'b0;
    idelay_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_load", 32'(dly_load), 32'd0);
    chk("rst_cnt", 32'(dly_cntvalue), 32'd0);
    chk("rst_busy", 32'(cal_busy), 32'd0);
    chk("rst_done", 32'(cal_done), 32'd0);
    chk("rst_fail", 32'(cal_fail), 32'd0);
    chk("rst_tap", 32'(cal_tap), 32'd0);
    @(negedge clk);
    RES_N      = 1'b1;
    idelay_rdy = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Single window 128..320
    gen_mode = 1;
    lo1 = 128; hi1 = 320; lo2 = -1; hi2 = -1;
    clear_log();
    pulse_start();
    wait_end(20000);
    chk("t1_done", 32'(cal_done), 32'd1);
    chk("t1_fail", 32'(cal_fail), 32'd0);
    chk("t1_busy", 32'(cal_busy), 32'd0);
    chk("t1_tap", 32'(cal_tap), 32'd224);
    chk("t1_cnt", 32'(dly_cntvalue), 32'd224);
    chk("t1_nload", 32'(lq.size()), 32'd17);
    if (lq.size() == 17) begin
      for (int i = 0; i < 16; i++)
        chk("t1_sweep", 32'(lq[i]), 32'(i * 32));
      chk("t1_final", 32'(lq[16]), 32'd224);
    end

    // Two windows, longer one wins
    lo1 = 32; hi1 = 96; lo2 = 256; hi2 = 352;
    clear_log();
    pulse_start();
    wait_end(20000);
    chk("t2_done", 32'(cal_done), 32'd1);
    chk("t2_tap", 32'(cal_tap), 32'd304);
    chk("t2_nload", 32'(lq.size()), 32'd17);
    if (lq.size() > 0)
      chk("t2_final", 32'(lq[$]), 32'd304);

    // Equal windows, lower one wins
    lo1 = 64; hi1 = 128; lo2 = 320; hi2 = 384;
    clear_log();
    pulse_start();
    wait_end(20000);
    chk("t3_done", 32'(cal_done), 32'd1);
    chk("t3_tap", 32'(cal_tap), 32'd96);

    // Every frame carries a wrong SFD
    gen_mode = 2;
    clear_log();
    pulse_start();
    wait_end(20000);
    chk("t4_fail", 32'(cal_fail), 32'd1);
    chk("t4_done", 32'(cal_done), 32'd0);
    chk("t4_busy", 32'(cal_busy), 32'd0);
    chk("t4_tap", 32'(cal_tap), 32'd0);
    chk("t4_cnt", 32'(dly_cntvalue), 32'd0);
    chk("t4_nload", 32'(lq.size()), 32'd17);
    if (lq.size() > 0)
      chk("t4_final", 32'(lq[$]), 32'd0);

    // Silent line: each point runs to the timeout
    gen_mode = 0;
    clear_log();
    pulse_start();
    wait_end(20000);
    chk("t5_fail", 32'(cal_fail), 32'd1);
    chk("t5_tap", 32'(cal_tap), 32'd0);
    chk("t5_nload", 32'(lq.size()), 32'd17);
    if (lq.size() == 17) begin
      chk("t5_gap_first", 32'(lt[1] - lt[0]), 32'd418);
      chk("t5_gap_last", 32'(lt[16] - lt[15]), 32'd418);
    end

    // Ready loss while measuring tap 160
    gen_mode = 1;
    lo1 = 128; hi1 = 320; lo2 = -1; hi2 = -1;
    clear_log();
    pulse_start();
    wait_load_v(160, 5000);
    repeat (20) @(negedge clk);
    idelay_rdy = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("t6_busy_wait", 32'(cal_busy), 32'd1);
    clear_log();
    repeat (30) @(posedge clk);
    #1;
    chk("t6_no_load", 32'(lq.size()), 32'd0);
    chk("t6_busy_hold", 32'(cal_busy), 32'd1);
    @(negedge clk);
    idelay_rdy = 1'b1;
    wait_load(200, v);
    chk("t6_restart_tap", 32'(v), 32'd0);
    wait_end(20000);
    chk("t6_done", 32'(cal_done), 32'd1);
    chk("t6_tap", 32'(cal_tap), 32'd224);

    // Reset mid-sweep at tap 64, long frames on an all-good channel
    data_len = 30;
    lo1 = 0; hi1 = 511;
    clear_log();
    pulse_start();
    wait_load_v(64, 5000);
    repeat (3) @(posedge clk);
    #2;
    RES_N = 1'b0;
    #1;
    chk("t7_rst_load", 32'(dly_load), 32'd0);
    chk("t7_rst_cnt", 32'(dly_cntvalue), 32'd0);
    chk("t7_rst_busy", 32'(cal_busy), 32'd0);
    chk("t7_rst_done", 32'(cal_done), 32'd0);
    chk("t7_rst_fail", 32'(cal_fail), 32'd0);
    chk("t7_rst_tap", 32'(cal_tap), 32'd0);
    @(negedge clk);
    RES_N = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_log();
    repeat (40) @(posedge clk);
    #1;
    chk("t7_no_load", 32'(lq.size()), 32'd0);
    chk("t7_idle", 32'(cal_busy), 32'd0);

    pulse_start();
    wait_load_v(32, 5000);
    pulse_start();
    wait_load(1000, v);
    chk("t7_start_ignored", 32'(v), 32'd64);
    wait_end(20000);
    chk("t7_done", 32'(cal_done), 32'd1);
    chk("t7_tap", 32'(cal_tap), 32'd240);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
